// File: rtl/event_out_fifo.sv
// Event output FIFO: buffers encoded address-events and presents them on a
// registered first-word-fall-through valid/ready stream with drop accounting.
module event_out_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12,
    parameter int CNT_W     = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     evt_valid_i,
    input  logic [WIDTH-1:0]         evt_data_i,
    output logic                     m_valid_o,
    output logic [WIDTH-1:0]         m_data_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     almost_full_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    input  logic                     clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wptr;
    logic [LW-1:0]    rptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    lvl_nxt;
    logic [LW-1:0]    settled;
    logic [AW-1:0]    rd_idx;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        level   = wptr - rptr;
        full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
        pop     = m_valid_o & m_ready_i;
        push    = evt_valid_i & (~full | pop);
        drop    = evt_valid_i & full & ~pop;
        lvl_nxt = level + LW'(push) - LW'(pop);
        // Only entries written before this edge feed the output register,
        // which gives the one-cycle fall-through latency with no bypass path.
        settled = level - LW'(pop);
        rd_idx  = rptr[AW-1:0] + AW'(pop);
    end

    assign level_o = level;

    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            mem[wptr[AW-1:0]] <= evt_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr          <= '0;
            rptr          <= '0;
            m_valid_o     <= 1'b0;
            m_data_o      <= '0;
            almost_full_o <= 1'b0;
            overflow_o    <= 1'b0;
            drop_cnt_o    <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + LW'(1);
            end
            if (pop) begin
                rptr <= rptr + LW'(1);
            end
            m_valid_o     <= (settled != '0);
            m_data_o      <= mem[rd_idx];
            almost_full_o <= (lvl_nxt >= LW'(AFULL_LVL));
            if (clr_i) begin
                overflow_o <= 1'b0;
                drop_cnt_o <= '0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) begin
                    drop_cnt_o <= drop_cnt_o + CNT_W'(1);
                end
            end
        end
    end
endmodule
